seg7_scan_reader: RTL
=====================

# seg7_scan_reader

- Receive-side companion to the team's BCD-to-7-segment encoder.
- Samples a multiplexed, active-low 7-segment bus (segments a–g plus one-hot active-low anodes) and reconstructs the BCD digit currently shown at each position.
- Filters each digit with a consecutive-sample stability check and flags illegal patterns.
- Used as a display-bus monitor/loopback checker in lab top levels and as a self-check target for display-driver verification.

## Interface
Parameters:
- DIGITS, 4, number of anode positions scanned (1–8).
- STABLE_CNT, 4, consecutive identical samples of one digit required before its output updates (2–15).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- seg  in  [0:6]  segment lines a..g, active-low; seg[0]=a, seg[6]=g.
- an  in  [DIGITS-1:0]  anode enables, active-low; bit i selects digit i.
- digits  out  [4*DIGITS-1:0]  accepted code per position; digit i in bits [4i+3:4i].
- digit_valid  out  [DIGITS-1:0]  bit i high once position i has an accepted code.
- update  out  1  one-cycle pulse when any digits field is written with a new value.
- illegal  out  1  one-cycle pulse when a selected digit carries an undecodable pattern.

## Operation
- Decode table (seg[0:6] → code):
  - 0000001→0, 1001111→1, 0010010→2, 0000110→3, 1001100→4, 0100100→5, 0100000→6, 0001111→7, 0000000→8, 0000100→9.
  - 1111110 (dash) → 4'hF, treated as legal.
  - Every other pattern is illegal.
- Sample qualification: a registered sample is used only if exactly one anode bit is low. Zero or multiple low bits are ignored, and no per-digit state changes.
- Per-digit state: candidate code `cand[i]` (4 bits) and run count `cnt[i]` (4 bits). Only the selected digit i is touched on a qualified sample:
  - Illegal pattern: `cnt[i]` ← 0, `illegal` pulses, `digits[i]`/`digit_valid[i]` unchanged.
  - Legal, code ≠ `cand[i]` or `cnt[i]`=0: `cand[i]` ← code, `cnt[i]` ← 1.
  - Legal, code = `cand[i]`: `cnt[i]` ← min(`cnt[i]`+1, STABLE_CNT).
  - When `cnt[i]` reaches STABLE_CNT (same edge) and (`digit_valid[i]`=0 or `digits[i]` ≠ code): write `digits[i]`, set `digit_valid[i]`, pulse `update`.
  - Re-confirming an already-accepted value writes nothing and gives no `update`.
- Samples of other digits between two samples of digit i do not break digit i's run.
- Reset values: `digits`=0, `digit_valid`=0, `update`=0, `illegal`=0, all `cand`/`cnt`=0, input registers cleared to seg=7'b1111111 and an=all-ones (blank, unqualified).

## Timing
- Input stage: `seg`/`an` are registered at edge t. Decode and per-digit update happen at edge t+1.
- Latency: if N = STABLE_CNT qualified identical samples of digit i are captured at edges t1..tN, `digits[i]` and `update` are visible after edge tN+1.
- `illegal` follows the illegal sample's capture edge by 1 cycle.
- `update` and `illegal` are high for exactly one cycle each, never held.
- One digit is processed per cycle, so the two pulses never refer to different digits in the same cycle.
- Reset asserted mid-run: all state returns to reset values at that edge, and a pending acceptance is discarded. After deassertion a digit needs a full STABLE_CNT run again.
- `cnt` saturates at STABLE_CNT and never wraps.

## Configuration
- `SEG7_READER_SYNC_EN` defined:
  - `seg` and `an` each pass through a two-flop synchronizer ahead of the input register, for asynchronous external buses.
  - All latencies in Timing grow by 2 cycles, and the synchronizer flops reset to blank/unqualified.
- Undefined: single input register only; inputs are assumed synchronous to `clk`.

## Test plan
- Reset, then an=4'b1110, seg=0000110 held for 4 cycles → `digits[3:0]`=3, `digit_valid`=4'b0001, one `update` pulse 1 cycle after the 4th capture.
- Scan digits 0..3 round-robin with codes 1,2,9,dash for 4 rounds → `digits`=16'hF921, `digit_valid`=4'hF, exactly four `update` pulses.
- Digit 1 shows 5,5,5,6,6,6,6 → no update during the 5s; `digits[7:4]`=6 only after the 4th 6; one `update`.
- seg=1111111 on an=4'b1011 → `illegal` pulses once, digit 2 run cleared, outputs unchanged. Then an=4'b1100 or 4'b1111 for 10 cycles → no state change, no pulses.
- Accept 7 on digit 0, show 7 for 8 more samples → no further `update`. Assert reset after 2 samples of a new value 4 → all outputs 0 and 4 is never accepted.
- With `SEG7_READER_SYNC_EN`, repeat the first scenario → `update` arrives 2 cycles later than without the macro.

Source files
------------

// File: rtl/seg7_scan_reader.sv
// Monitors a multiplexed active-low 7-segment bus and rebuilds the stable BCD code per digit.
// Optional: define SEG7_READER_SYNC_EN to add two-flop synchronizers on seg/an.
module seg7_scan_reader #(
    parameter int DIGITS     = 4,
    parameter int STABLE_CNT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:6]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  update,
    output logic                  illegal
);

    localparam int         SEL_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [3:0] STABLE = 4'(STABLE_CNT);

    logic [0:6]        seg_q;
    logic [DIGITS-1:0] an_q;

`ifdef SEG7_READER_SYNC_EN
    logic [0:6]        seg_s1, seg_s2;
    logic [DIGITS-1:0] an_s1, an_s2;

    // Reset values represent a blank, unqualified bus at every stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_s1 <= '1;
            seg_s2 <= '1;
            seg_q  <= '1;
            an_s1  <= '1;
            an_s2  <= '1;
            an_q   <= '1;
        end else begin
            seg_s1 <= seg;
            seg_s2 <= seg_s1;
            seg_q  <= seg_s2;
            an_s1  <= an;
            an_s2  <= an_s1;
            an_q   <= an_s2;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q <= '1;
            an_q  <= '1;
        end else begin
            seg_q <= seg;
            an_q  <= an;
        end
    end
`endif

    logic [3:0] code;
    logic       legal;

    always_comb begin
        legal = 1'b1;
        code  = 4'd0;
        case (seg_q)
            7'b0000001: code = 4'd0;
            7'b1001111: code = 4'd1;
            7'b0010010: code = 4'd2;
            7'b0000110: code = 4'd3;
            7'b1001100: code = 4'd4;
            7'b0100100: code = 4'd5;
            7'b0100000: code = 4'd6;
            7'b0001111: code = 4'd7;
            7'b0000000: code = 4'd8;
            7'b0000100: code = 4'd9;
            7'b1111110: code = 4'hF;
            default:    legal = 1'b0;
        endcase
    end

    logic             qualified;
    logic [SEL_W-1:0] sel;

    // A sample counts only when exactly one anode is driven low.
    always_comb begin
        qualified = $onehot(~an_q);
        sel       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_q[i]) sel = SEL_W'(i);
        end
    end

    logic [3:0] cand [DIGITS];
    logic [3:0] cnt  [DIGITS];
    logic [3:0] cur_cand, cur_cnt, cur_digit, next_cand, next_cnt;
    logic       accept;

    always_comb begin
        cur_cand  = cand[sel];
        cur_cnt   = cnt[sel];
        cur_digit = digits[4*int'(sel) +: 4];
        next_cand = cur_cand;
        next_cnt  = cur_cnt;
        if (!legal) begin
            next_cnt = 4'd0;
        end else if (code != cur_cand || cur_cnt == 4'd0) begin
            next_cand = code;
            next_cnt  = 4'd1;
        end else if (cur_cnt < STABLE) begin
            next_cnt = 4'(cur_cnt + 4'd1);
        end
        // Re-confirming the value already on display must not re-announce it.
        accept = legal && (next_cnt == STABLE) && (!digit_valid[sel] || cur_digit != code);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digits      <= '0;
            digit_valid <= '0;
            update      <= 1'b0;
            illegal     <= 1'b0;
            for (int i = 0; i < DIGITS; i++) begin
                cand[i] <= 4'd0;
                cnt[i]  <= 4'd0;
            end
        end else begin
            update  <= 1'b0;
            illegal <= 1'b0;
            if (qualified) begin
                cand[sel] <= next_cand;
                cnt[sel]  <= next_cnt;
                if (!legal) illegal <= 1'b1;
                if (accept) begin
                    digits[4*int'(sel) +: 4] <= code;
                    digit_valid[sel]         <= 1'b1;
                    update                   <= 1'b1;
                end
            end
        end
    end

endmodule
